// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending-latch front end: channel count,
// index width and the arbitration FSM state encoding.
package irq_pkg;

  localparam int unsigned IRQ_N_CH  = 4;
  localparam int unsigned IRQ_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARB      = 2'd1,
    WAIT_ACK = 2'd2,
    CLEAR    = 2'd3
  } irq_state_e;

  function automatic logic [IRQ_N_CH-1:0] idx_onehot(input logic [IRQ_IDX_W-1:0] idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-channel synchroniser chain plus history flop; flags a rising edge of
// the synchronised request for one clock.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_in,
  output logic edge_evt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign edge_evt = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/irq_pending_latch.sv
// Four-channel interrupt front end: latches synchronised request edges, drives
// an external priority encoder, and offers the chosen index over valid/ack.
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      irq_in,
  input  logic [N_CH-1:0]      mask,
  output logic [N_CH-1:0]      enc_d,
  output logic                 enc_en,
  input  logic [IRQ_IDX_W-1:0] enc_out,
  output logic                 irq_valid,
  output logic [IRQ_IDX_W-1:0] irq_id,
  input  logic                 irq_ack,
  output logic [N_CH-1:0]      pending,
  output logic [N_CH-1:0]      overrun,
  input  logic [N_CH-1:0]      ovr_clr
);

  irq_state_e           r_state, w_state_next;
  logic [N_CH-1:0]      r_pending, r_overrun;
  logic                 r_enc_en, r_valid;
  logic [IRQ_IDX_W-1:0] r_id;

  logic [N_CH-1:0]      w_edge;
  logic [N_CH-1:0]      w_enc_d;
  logic [N_CH-1:0]      w_clr_vec;
  logic                 w_valid_next;
  logic [IRQ_IDX_W-1:0] w_id_next;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .irq_in  (irq_in[g]),
      .edge_evt(w_edge[g])
    );
  end

  assign w_enc_d   = r_pending & ~mask;
  assign w_clr_vec = (r_state == CLEAR) ? idx_onehot(r_id) : '0;

  // Set has priority over the service clear; an edge landing in the CLEAR
  // cycle of its own channel re-arms pending without counting as overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_vec) | w_edge;
      r_overrun <= (r_overrun & ~ovr_clr) | (w_edge & r_pending & ~w_clr_vec);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_valid;
    w_id_next    = r_id;
    case (r_state)
      IDLE: begin
        if (|w_enc_d) w_state_next = ARB;
      end
      ARB: begin
        if (|w_enc_d) begin
          w_id_next    = enc_out;
          w_valid_next = 1'b1;
          w_state_next = WAIT_ACK;
        end else begin
          w_state_next = IDLE;
        end
      end
      WAIT_ACK: begin
        if (irq_ack) begin
          w_valid_next = 1'b0;
          w_state_next = CLEAR;
        end
      end
      CLEAR: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_enc_en <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_valid  <= w_valid_next;
      r_id     <= w_id_next;
      r_enc_en <= (w_state_next == ARB);
    end
  end

  assign enc_d     = w_enc_d;
  assign enc_en    = r_enc_en;
  assign irq_valid = r_valid;
  assign irq_id    = r_id;
  assign pending   = r_pending;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch paired with a behavioural 4-bit
// highest-index-wins priority encoder.
module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_in;
  logic [3:0] mask;
  logic [3:0] enc_d;
  logic       enc_en;
  logic [1:0] enc_out;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic [3:0] pending;
  logic [3:0] overrun;
  logic [3:0] ovr_clr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign enc_out = enc_d[3] ? 2'd3 : enc_d[2] ? 2'd2 : enc_d[1] ? 2'd1 : 2'd0;

  irq_pending_latch #(
    .N_CH       (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .mask     (mask),
    .enc_d    (enc_d),
    .enc_en   (enc_en),
    .enc_out  (enc_out),
    .irq_valid(irq_valid),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack),
    .pending  (pending),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] v);
    irq_in = v;
    tick();
    irq_in = '0;
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    irq_in  = '0;
    mask    = '0;
    irq_ack = 1'b0;
    ovr_clr = '0;
    tick();
    tick();
    chk("rst_valid",   {7'd0, irq_valid}, 8'd0);
    chk("rst_id",      {6'd0, irq_id},    8'd0);
    chk("rst_enc_en",  {7'd0, enc_en},    8'd0);
    chk("rst_pending", {4'd0, pending},   8'd0);
    chk("rst_overrun", {4'd0, overrun},   8'd0);
    rst_n = 1'b1;
    tick();

    // single request on channel 2
    pulse(4'b0100);
    tick();
    chk("t1_pend_e2", {4'd0, pending}, 8'h0);
    tick();
    chk("t1_pend_e3", {4'd0, pending}, 8'h4);
    chk("t1_val_e3",  {7'd0, irq_valid}, 8'd0);
    tick();
    chk("t1_enc_en_e4", {7'd0, enc_en}, 8'd1);
    chk("t1_enc_d_e4",  {4'd0, enc_d},  8'h4);
    tick();
    chk("t1_val_e5",    {7'd0, irq_valid}, 8'd1);
    chk("t1_id_e5",     {6'd0, irq_id},    8'd2);
    chk("t1_enc_en_e5", {7'd0, enc_en},    8'd0);
    ack_once();
    chk("t1_val_a",  {7'd0, irq_valid}, 8'd0);
    chk("t1_pend_a", {4'd0, pending},   8'h4);
    tick();
    chk("t1_pend_a1", {4'd0, pending}, 8'h0);
    tick();
    chk("t1_idle_en", {7'd0, enc_en}, 8'd0);
    tick();

    // priority: channels 0 and 3 together
    pulse(4'b1001);
    tick();
    tick();
    chk("t2_pend", {4'd0, pending}, 8'h9);
    tick();
    tick();
    chk("t2_val1", {7'd0, irq_valid}, 8'd1);
    chk("t2_id1",  {6'd0, irq_id},    8'd3);
    ack_once();
    chk("t2_val_a", {7'd0, irq_valid}, 8'd0);
    tick();
    chk("t2_pend_a1", {4'd0, pending}, 8'h1);
    tick();
    chk("t2_val_a2", {7'd0, irq_valid}, 8'd0);
    chk("t2_en_a2",  {7'd0, enc_en},    8'd1);
    tick();
    chk("t2_val_a3", {7'd0, irq_valid}, 8'd1);
    chk("t2_id_a3",  {6'd0, irq_id},    8'd0);
    ack_once();
    tick();
    chk("t2_pend_end", {4'd0, pending}, 8'h0);
    tick();

    // mask channel 3 with channels 3 and 1 pending
    mask = 4'b1000;
    pulse(4'b1010);
    tick();
    tick();
    chk("t3_pend",  {4'd0, pending}, 8'hA);
    chk("t3_enc_d", {4'd0, enc_d},   8'h2);
    tick();
    tick();
    chk("t3_val1",  {7'd0, irq_valid}, 8'd1);
    chk("t3_id1",   {6'd0, irq_id},    8'd1);
    ack_once();
    tick();
    chk("t3_pend_keep3", {4'd0, pending}, 8'h8);
    mask = 4'b0000;
    tick();
    tick();
    chk("t3_val2", {7'd0, irq_valid}, 8'd1);
    chk("t3_id2",  {6'd0, irq_id},    8'd3);
    ack_once();
    tick();
    chk("t3_pend_end", {4'd0, pending}, 8'h0);
    tick();

    // overrun on channel 2, W1C, then edge during its CLEAR cycle
    pulse(4'b0100);
    tick();
    irq_in = 4'b0100;
    tick();
    chk("t4_pend",   {4'd0, pending}, 8'h4);
    chk("t4_ovr0",   {4'd0, overrun}, 8'h0);
    irq_in = 4'b0000;
    tick();
    tick();
    chk("t4_val",    {7'd0, irq_valid}, 8'd1);
    chk("t4_id",     {6'd0, irq_id},    8'd2);
    chk("t4_ovr",    {4'd0, overrun},   8'h4);
    ovr_clr = 4'b0100;
    tick();
    ovr_clr = 4'b0000;
    chk("t4_ovr_clr", {4'd0, overrun},   8'h0);
    chk("t4_val_hold", {7'd0, irq_valid}, 8'd1);
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    ack_once();
    chk("t4_val_a", {7'd0, irq_valid}, 8'd0);
    tick();
    chk("t4_clr_pend", {4'd0, pending}, 8'h4);
    chk("t4_clr_ovr",  {4'd0, overrun}, 8'h0);
    tick();
    tick();
    chk("t4_reoffer_val", {7'd0, irq_valid}, 8'd1);
    chk("t4_reoffer_id",  {6'd0, irq_id},    8'd2);
    ack_once();
    tick();
    chk("t4_pend_end", {4'd0, pending}, 8'h0);
    tick();

    // mask race: full mask applied in the ARB cycle
    pulse(4'b0010);
    tick();
    tick();
    chk("t5_pend", {4'd0, pending}, 8'h2);
    tick();
    chk("t5_arb_en", {7'd0, enc_en}, 8'd1);
    mask = 4'b1111;
    tick();
    chk("t5_val_none", {7'd0, irq_valid}, 8'd0);
    chk("t5_en_off",   {7'd0, enc_en},    8'd0);
    tick();
    chk("t5_val_none2", {7'd0, irq_valid}, 8'd0);
    chk("t5_pend_keep", {4'd0, pending},   8'h2);
    mask = 4'b0000;
    tick();
    tick();
    chk("t5_val_after", {7'd0, irq_valid}, 8'd1);
    chk("t5_id_after",  {6'd0, irq_id},    8'd1);
    ack_once();
    tick();
    tick();

    // asynchronous reset while offering channel 3 with overrun set
    pulse(4'b1000);
    tick();
    irq_in = 4'b1000;
    tick();
    irq_in = 4'b0000;
    tick();
    tick();
    chk("t6_val_pre", {7'd0, irq_valid}, 8'd1);
    chk("t6_ovr_pre", {4'd0, overrun},   8'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_val_rst",  {7'd0, irq_valid}, 8'd0);
    chk("t6_pend_rst", {4'd0, pending},   8'h0);
    chk("t6_ovr_rst",  {4'd0, overrun},   8'h0);
    tick();
    rst_n = 1'b1;
    tick();
    ack_once();
    chk("t6_stray_val",  {7'd0, irq_valid}, 8'd0);
    chk("t6_stray_pend", {4'd0, pending},   8'h0);
    tick();
    tick();
    chk("t6_stray_en",   {7'd0, enc_en},    8'd0);
    chk("t6_stray_val2", {7'd0, irq_valid}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Four-channel interrupt front end that sits directly upstream of the 4-bit priority encoder. It synchronises raw request lines, detects rising edges, and latches them into a pending register. It drives the masked pending vector and enable into the encoder, then captures the encoder's 2-bit index and presents it to the consumer through a valid/ack handshake. On acknowledge it clears the serviced pending bit.

## Interface
- `N_CH`, 4, channel count; fixed at 4 to match the encoder width.
- `SYNC_STAGES`, 2, synchroniser depth on `irq_in`; legal values 2–3.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_in`  in  4  raw request lines, asynchronous to `clk`.
- `mask`  in  4  1 = channel masked from arbitration; the channel still latches.
- `enc_d`  out  4  `pending & ~mask`, to the encoder `d`; combinational from registers.
- `enc_en`  out  1  encoder enable; registered, high only in state ARB.
- `enc_out`  in  2  encoder index; sampled only in ARB.
- `irq_valid`  out  1  registered; high while `irq_id` is being offered.
- `irq_id`  out  2  registered serviced channel index.
- `irq_ack`  in  1  consumer accept; effective only when `irq_valid`=1.
- `pending`  out  4  raw pending register, for status.
- `overrun`  out  4  sticky: a new edge arrived while the channel was already pending.
- `ovr_clr`  in  4  write-one-to-clear for `overrun`.

## Operation
- Synchroniser: a `SYNC_STAGES`-flop chain per channel, followed by one history flop. An edge event is `sync_last & ~hist`.
- Pending: a set on an edge event. A clear applies to bit `irq_id` only in state CLEAR. If set and clear hit the same bit in the same cycle, set wins.
- Overrun: set when an edge event hits a bit that is already pending, except in the CLEAR cycle for that bit. It is cleared by `ovr_clr`. If set and clear coincide, set wins.
- FSM (2-bit state; reset state IDLE):
  - IDLE: if `enc_d`≠0, go to ARB; otherwise stay.
  - ARB: `enc_en`=1. If `enc_d`≠0 (mask can change between cycles), load `irq_id`←`enc_out`, set `irq_valid`←1, and go to WAIT_ACK. If `enc_d`=0, go to IDLE without asserting valid.
  - WAIT_ACK: hold `irq_valid` and `irq_id` stable until `irq_ack`=1. On ack, clear `irq_valid` and go to CLEAR.
  - CLEAR: clear `pending[irq_id]`, then go to IDLE.
- Masking a channel after its index is captured does not withdraw the offer.
- `irq_ack` is ignored outside WAIT_ACK.
- Encoder `z`/`x` outputs are never sampled: `enc_en`=0 outside ARB, and ARB is always entered with `enc_d`≠0.

## Timing
- Reset values: `enc_en`=0, `irq_valid`=0, `irq_id`=0, `pending`=0, `overrun`=0, sync/history flops 0, state IDLE. Reset is asynchronous assert and synchronous-safe deassert; the block does not generate the reset.
- Edge to pending: `irq_in` rises before clock edge E1 → pending bit is 1 after edge E(SYNC_STAGES+1), i.e. E3 at the default depth.
- Pending to valid: pending visible at edge P → state ARB after P+1 → `irq_valid`=1 after P+2.
- With the default depth, `irq_in` to `irq_valid` takes 5 cycles.
- Ack: `irq_ack` high at edge A → `irq_valid`=0 after A. The pending bit clears at A+1, and state is IDLE after A+1.
- The next arbitration can raise `irq_valid` at A+3 at the earliest.
- Throughput: one interrupt per 4 cycles minimum, with ack on the first valid cycle.
- Reset mid-handshake: `irq_valid` drops immediately and all pending requests are lost.

## Structure
- Shared package `irq_pkg`:
  - FSM state encoding: IDLE=0, ARB=1, WAIT_ACK=2, CLEAR=3.
  - `N_CH`=4 and the index width of 2.
- Sub-module `irq_sync_edge`: per-channel synchroniser plus edge detector, instantiated 4×.
- The encoder itself stays outside; the bench instantiates both blocks together.

## Test plan
- Single request: pulse `irq_in`=4'b0100 for 1 cycle after reset → `irq_valid`=1 with `irq_id`=2 at cycle 5. Ack → `pending`=0 one cycle later.
- Priority: raise channels 0 and 3 in the same cycle → first `irq_id`=3. After ack, the second offer is `irq_id`=0, starting 3 cycles after ack.
- Mask: `mask`=4'b1000 with channels 3 and 1 pending → `irq_id`=1, and `pending[3]` stays 1. Drop the mask → next offer is `irq_id`=3.
- Overrun: second edge on channel 2 while it is pending → `overrun`=4'b0100. Assert `ovr_clr`=4'b0100 → 0. An edge on channel 2 during its CLEAR cycle → pending stays 1 and overrun stays 0.
- Mask race: set `mask`=4'b1111 in the cycle state enters ARB → no `irq_valid` is asserted and state returns to IDLE.
- Async reset: assert `rst_n`=0 while in WAIT_ACK → `irq_valid`, `pending`, and `overrun` are 0 immediately, and a stray `irq_ack` after release has no effect.
